// File: rtl/onehot_decoder_scan_if.sv
// rtl/onehot_decoder_scan_if.sv - select/scan control and one-hot result bundle for onehot_decoder_scan
interface onehot_decoder_scan_if #(
    parameter int SEL_W   = 6,
    parameter int OUT_W   = 64,
    parameter int DWELL_W = 8
);
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   input_line;
    logic               scan_start;
    logic               scan_stop;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   output_line;
    logic               out_valid;
    logic               busy;
    logic               err;

    modport master (
        output mode, in_valid, input_line, scan_start, scan_stop, dwell,
        input  in_ready, output_line, out_valid, busy, err
    );

    modport slave (
        input  mode, in_valid, input_line, scan_start, scan_stop, dwell,
        output in_ready, output_line, out_valid, busy, err
    );
endinterface

// File: rtl/onehot_decoder_scan.sv
// rtl/onehot_decoder_scan.sv - registered one-hot decoder with range check and walking-one scan
module onehot_decoder_scan #(
    parameter int SEL_W   = 6,
    parameter int OUT_W   = 64,
    parameter int DWELL_W = 8
) (
    input logic                  clk,
    input logic                  rst,
    onehot_decoder_scan_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SCAN
    } state_t;

    localparam logic [SEL_W:0]   OUT_LIMIT = (SEL_W+1)'(OUT_W);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(OUT_W - 1);

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwl_q, dwl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dwl_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dwl_q   <= dwl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dwl_d   = dwl_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (bus.mode) begin
                    // a simultaneous stop vetoes the start
                    if (bus.scan_start && !bus.scan_stop) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                        cnt_d   = '0;
                        dwl_d   = bus.dwell;
                        out_d   = OUT_W'(1);
                        valid_d = 1'b1;
                    end
                end else if (bus.in_valid) begin
                    valid_d = 1'b1;
                    if ({1'b0, bus.input_line} < OUT_LIMIT) begin
                        out_d   = OUT_W'(1) << bus.input_line;
                        state_d = ST_HOLD;
                    end else begin
                        out_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SCAN: begin
                if (bus.scan_stop) begin
                    state_d = ST_IDLE;
                    out_d   = '0;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == dwl_q) begin
                    // wrap at OUT_W-1 so non-power-of-two widths never select a missing line
                    cnt_d   = '0;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    out_d   = OUT_W'(1) << idx_d;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready    = (state_q != ST_SCAN) && !bus.mode;
    assign bus.output_line = out_q;
    assign bus.out_valid   = valid_q;
    assign bus.busy        = (state_q == ST_SCAN);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_onehot_decoder_scan.sv
// tb/tb_onehot_decoder_scan.sv - directed vector bench for onehot_decoder_scan
module tb_onehot_decoder_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    onehot_decoder_scan_if #(.SEL_W(6), .OUT_W(64), .DWELL_W(8)) if64 ();
    onehot_decoder_scan_if #(.SEL_W(6), .OUT_W(48), .DWELL_W(8)) if48 ();
    onehot_decoder_scan_if #(.SEL_W(4), .OUT_W(10), .DWELL_W(8)) if10 ();

    onehot_decoder_scan #(.SEL_W(6), .OUT_W(64), .DWELL_W(8)) u64 (.clk(clk), .rst(rst), .bus(if64));
    onehot_decoder_scan #(.SEL_W(6), .OUT_W(48), .DWELL_W(8)) u48 (.clk(clk), .rst(rst), .bus(if48));
    onehot_decoder_scan #(.SEL_W(4), .OUT_W(10), .DWELL_W(8)) u10 (.clk(clk), .rst(rst), .bus(if10));

    typedef struct {
        logic        mode;
        logic        in_valid;
        logic [5:0]  sel;
        logic        exp_ready;
        logic [63:0] exp_out;
        logic        exp_valid;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 6'd5,  1'b1, 64'h0000_0000_0000_0020, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 6'd63, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 6'd0,  1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 6'd2,  1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 6'd0,  1'b1, 64'h0000_0000_0000_0001, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 6'd32, 1'b1, 64'h0000_0001_0000_0000, 1'b1, 1'b0};

        if64.mode = 0; if64.in_valid = 0; if64.input_line = '0; if64.scan_start = 0; if64.scan_stop = 0; if64.dwell = '0;
        if48.mode = 0; if48.in_valid = 0; if48.input_line = '0; if48.scan_start = 0; if48.scan_stop = 0; if48.dwell = '0;
        if10.mode = 0; if10.in_valid = 0; if10.input_line = '0; if10.scan_start = 0; if10.scan_stop = 0; if10.dwell = '0;

        rst = 1'b1;
        tick(); tick();
        check("reset_out64", if64.output_line, 64'h0);
        check("reset_valid64", if64.out_valid, 0);
        check("reset_err64", if64.err, 0);
        check("reset_busy64", if64.busy, 0);
        check("reset_ready64", if64.in_ready, 1);
        check("reset_out48", if48.output_line, 64'h0);
        check("reset_out10", if10.output_line, 64'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            if64.mode = vecs[i].mode;
            if64.in_valid = vecs[i].in_valid;
            if64.input_line = vecs[i].sel;
            #1;
            check($sformatf("vec%0d_ready", i), if64.in_ready, vecs[i].exp_ready);
            tick();
            check($sformatf("vec%0d_out", i), if64.output_line, vecs[i].exp_out);
            check($sformatf("vec%0d_valid", i), if64.out_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_err", i), if64.err, vecs[i].exp_err);
        end

        if64.mode = 0; if64.in_valid = 1;
        for (int i = 0; i < 64; i++) begin
            if64.input_line = 6'(i);
            tick();
            check($sformatf("sweep%0d_out", i), if64.output_line, 64'd1 << i);
            check($sformatf("sweep%0d_valid", i), if64.out_valid, 1);
        end

        if48.mode = 0; if48.in_valid = 1; if48.input_line = 6'd50;
        tick();
        check("r48_50_out", if48.output_line, 64'h0);
        check("r48_50_err", if48.err, 1);
        check("r48_50_valid", if48.out_valid, 1);
        if48.input_line = 6'd48;
        tick();
        check("r48_48_out", if48.output_line, 64'h0);
        check("r48_48_err", if48.err, 1);
        if48.input_line = 6'd47;
        tick();
        check("r48_47_out", if48.output_line, 64'h0000_8000_0000_0000);
        check("r48_47_err", if48.err, 0);
        check("r48_47_valid", if48.out_valid, 1);
        if48.in_valid = 0;
        tick();
        check("r48_idle_out", if48.output_line, 64'h0000_8000_0000_0000);
        check("r48_idle_valid", if48.out_valid, 0);
        check("r48_idle_err", if48.err, 0);
        if48.mode = 1; if48.scan_stop = 1;
        tick();
        check("r48_stop_ignored_out", if48.output_line, 64'h0000_8000_0000_0000);
        check("r48_stop_ignored_valid", if48.out_valid, 0);
        check("r48_stop_ignored_busy", if48.busy, 0);
        if48.scan_stop = 0;

        // dwell=2 scan entered from HOLD; dwell port and mode are disturbed mid-scan
        if64.mode = 1; if64.in_valid = 1; if64.input_line = 6'd3; if64.dwell = 8'd2; if64.scan_start = 1;
        tick();
        check("scan_entry_out", if64.output_line, 64'h1);
        check("scan_entry_valid", if64.out_valid, 1);
        check("scan_entry_busy", if64.busy, 1);
        check("scan_entry_ready", if64.in_ready, 0);
        if64.scan_start = 0;
        if64.dwell = 8'd0;
        for (int k = 1; k <= 195; k++) begin
            if (k == 100) if64.mode = 0;
            tick();
            check($sformatf("scan_k%0d_out", k), if64.output_line, 64'd1 << ((k / 3) % 64));
            check($sformatf("scan_k%0d_valid", k), if64.out_valid, (k % 3) == 0);
            check($sformatf("scan_k%0d_busy", k), if64.busy, 1);
            check($sformatf("scan_k%0d_ready", k), if64.in_ready, 0);
        end
        if64.in_valid = 0;
        if64.scan_stop = 1;
        tick();
        check("scan_stop_out", if64.output_line, 64'h0);
        check("scan_stop_valid", if64.out_valid, 1);
        check("scan_stop_busy", if64.busy, 0);
        if64.scan_stop = 0;
        tick();
        check("after_stop_valid", if64.out_valid, 0);
        check("after_stop_ready", if64.in_ready, 1);

        if64.mode = 1; if64.dwell = 8'd0; if64.scan_start = 1;
        tick();
        if64.scan_start = 0;
        repeat (7) tick();
        check("stop7_pre_out", if64.output_line, 64'h80);
        if64.scan_stop = 1;
        tick();
        check("stop7_out", if64.output_line, 64'h0);
        check("stop7_valid", if64.out_valid, 1);
        check("stop7_busy", if64.busy, 0);

        if64.scan_start = 1;
        tick();
        check("collide_busy", if64.busy, 0);
        check("collide_out", if64.output_line, 64'h0);
        check("collide_valid", if64.out_valid, 0);
        if64.scan_start = 0; if64.scan_stop = 0;

        if10.mode = 1; if10.dwell = 8'd0; if10.scan_start = 1;
        tick();
        check("w10_entry_out", if10.output_line, 64'h1);
        if10.scan_start = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("w10_k%0d_out", k), if10.output_line, 64'd1 << (k % 10));
            check($sformatf("w10_k%0d_valid", k), if10.out_valid, 1);
        end
        repeat (5) tick();
        check("w10_bit7_out", if10.output_line, 64'h80);
        rst = 1'b1;
        tick();
        check("rst7_out", if10.output_line, 64'h0);
        check("rst7_valid", if10.out_valid, 0);
        check("rst7_busy", if10.busy, 0);
        rst = 1'b0;
        tick();
        check("rst7_after_out", if10.output_line, 64'h0);
        check("rst7_after_valid", if10.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/onehot_decoder_scan.md
Name: onehot_decoder_scan

Overview:
- Parametrised, registered successor to the fixed 6-to-64 one-hot decoder.
- Decodes an SEL_W-bit select into a one-hot output of OUT_W lines.
- Adds three things the combinational block lacks: a valid/ready input handshake, range checking, and an autonomous walking-one scan mode with programmable dwell.
- Drives row/bank enables and LED/test-pattern sequencing in the lab designs.

Parameters:
- SEL_W, 6: select width.
- OUT_W, 64: number of one-hot outputs; legal range 2..2**SEL_W.
- DWELL_W, 8: width of the dwell (hold-time) field.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: synchronous active-high reset.
- mode, input, 1: 0 = direct decode, 1 = scan.
- in_valid, input, 1: input_line holds a select to decode.
- in_ready, output, 1: block accepts a select this cycle.
- input_line, input, SEL_W: select value.
- scan_start, input, 1: begin walking-one scan.
- scan_stop, input, 1: end scan.
- dwell, input, DWELL_W: cycles-minus-one each output is held in scan mode.
- output_line, output, OUT_W: registered one-hot (or all-zero) output.
- out_valid, output, 1: one-cycle pulse when output_line updates.
- busy, output, 1: high while in SCAN.
- err, output, 1: one-cycle pulse when an out-of-range select is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high at an edge: output_line=0, out_valid=0, err=0, busy=0, scan index=0, dwell counter=0, state=IDLE. Reset mid-scan aborts the scan with no extra out_valid.
- States: IDLE (output zero), HOLD (direct value held), SCAN.
- in_ready is combinational: (state != SCAN) && (mode == 0).
- Direct transfer: occurs when in_valid && in_ready. At the next edge:
  - output_line = 1 << input_line if input_line < OUT_W, and state becomes HOLD.
  - Otherwise output_line = 0, err=1 for one cycle, and state becomes IDLE.
  - out_valid=1 for one cycle in both cases.
  - Latency: 1 cycle from transfer to output.
- No transfer: output_line holds its value; out_valid=0 and err=0.
- In mode=1, in_valid is ignored. In mode=0, scan_start is ignored.
- Scan entry: scan_start && mode==1 in IDLE/HOLD. At the next edge:
  - index=0, output_line=1 (bit 0), out_valid=1.
  - dwell value latched internally; dwell counter=0.
  - state=SCAN, busy=1.
- Scan step: in SCAN, the dwell counter increments each cycle. When it equals the latched dwell:
  - counter resets to 0 and the index advances.
  - When index = OUT_W-1 it wraps to 0 (non-power-of-two OUT_W wraps at OUT_W-1, not 2**SEL_W-1).
  - output_line = 1 << new index, out_valid=1 for one cycle.
  - Each bit is therefore held dwell+1 cycles. dwell=0 gives a new bit every cycle.
- The latched dwell is unaffected by changes on the dwell port during a scan.
- Scan exit: scan_stop in SCAN. At the next edge: output_line=0, out_valid=1, busy=0, state=IDLE, index=0.
  - scan_stop outside SCAN is ignored.
  - scan_stop and scan_start asserted together: scan_stop wins; a scan start is not performed.
  - A mode change to 0 during SCAN does not stop the scan; only scan_stop or rst does.
- output_line is always zero or exactly one-hot. It never has more than one bit set and never changes except at an out_valid pulse or reset.

Test Plan:
- Reset then direct decode (SEL_W=6, OUT_W=64): mode=0, in_valid=1, input_line=6'd5 → after 1 edge, output_line=64'h20, out_valid pulse, err=0. Then input_line=6'd63 → output_line=64'h8000_0000_0000_0000. Sweep all 64 values, checking exactly one bit set at the index.
- Range check (OUT_W=48): input_line=6'd50 → output_line=0, err pulse, state IDLE. Then input_line=6'd47 → bit 47 set, err=0.
- Scan with dwell=2: mode=1, scan_start → bit0 for 3 cycles, then bit1, bit2… out_valid every 3rd cycle. After bit63, wraps to bit0. in_ready=0 and busy=1 throughout.
- Scan wrap for non-power-of-two (OUT_W=10, dwell=0): bits 0..9 then 0 on consecutive cycles.
- Stop/start collision and abort:
  - scan_start+scan_stop same cycle from IDLE → no scan.
  - In SCAN at bit 7: scan_stop → output_line=0, busy=0, out_valid pulse.
  - In SCAN at bit 7: rst instead → output_line=0, no out_valid.
- Handshake hold: in_valid=1 with mode=1 or during SCAN → no transfer, output_line unchanged. Changing dwell mid-scan does not alter the hold length.
